// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select.
// Uses a bounded hold time: an owner yields after MAX_HOLD cycles
// when the other source is also requesting.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [1:0]       gnt_q, gnt_d;

    logic owner;
    logic enter;
    logic enter_idx;

    // Next-state: arbitration, hold counter and round-robin pointer
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        enter      = 1'b0;
        enter_idx  = 1'b0;
        owner      = (state_q == StOwn1);

        case (state_q)
            StIdle: begin
                if (req == 2'b11) begin
                    enter     = 1'b1;
                    enter_idx = ~last_q;
                end else if (req[0]) begin
                    enter     = 1'b1;
                    enter_idx = 1'b0;
                end else if (req[1]) begin
                    enter     = 1'b1;
                    enter_idx = 1'b1;
                end
            end
            default: begin
                if (!req[owner]) begin
                    // Owner released: hand off directly, or go idle
                    if (req[~owner]) begin
                        enter     = 1'b1;
                        enter_idx = ~owner;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (req[~owner] && (hold_cnt_q == HoldMax)) begin
                    enter     = 1'b1;
                    enter_idx = ~owner;
                end else if (hold_cnt_q != HoldMax) begin
                    // Saturating count so an uncontested owner never wraps
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (enter) begin
            state_d    = enter_idx ? StOwn1 : StOwn0;
            hold_cnt_d = '0;
            last_d     = enter_idx;
        end
    end

    // Registered outputs decoded from the next state; sel holds in idle
    always_comb begin
        gnt_d = 2'b00;
        sel_d = sel_q;
        case (state_d)
            StOwn0: begin
                gnt_d = 2'b01;
                sel_d = 1'b0;
            end
            StOwn1: begin
                gnt_d = 2'b10;
                sel_d = 1'b1;
            end
            default: begin
                gnt_d = 2'b00;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            gnt_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus
// randomized traffic against a tenure-based reference model.
module tb_mux_sel_arbiter;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;

    int vectors;
    int miscompares;

    // Reference model: owner (-1 = none), cycles kept so far, last winner
    int m_owner;
    int m_tenure;
    int m_last;
    int m_sel;

    mux_sel_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_gnt();
        if (m_owner == 0) return 2'b01;
        if (m_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_grant(input int who);
        m_owner  = who;
        m_tenure = 0;
        m_last   = who;
        m_sel    = who;
    endtask

    task automatic model_step(input logic rst_b, input logic [1:0] r);
        int other;
        if (!rst_b) begin
            m_owner = -1; m_tenure = 0; m_last = 1; m_sel = 0;
        end else if (m_owner < 0) begin
            if (r == 2'b11)      model_grant(1 - m_last);
            else if (r == 2'b01) model_grant(0);
            else if (r == 2'b10) model_grant(1);
        end else begin
            other = 1 - m_owner;
            if (!r[m_owner]) begin
                if (r[other]) model_grant(other);
                else m_owner = -1;
            end else if (r[other] && m_tenure >= MAX_HOLD - 1) begin
                model_grant(other);
            end else begin
                m_tenure++;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model
    task automatic tick(input logic rst_b, input logic [1:0] r);
        rst_n = rst_b;
        req   = r;
        @(posedge clk);
        model_step(rst_b, r);
        #1;
    endtask

    // Structural invariants checked every cycle away from the active edge
    always @(negedge clk) begin
        vectors++;
        if (gnt === 2'b11 || busy !== |gnt || (busy && sel !== gnt[1])) begin
            miscompares++;
            $display("FAIL invariant: gnt=%b busy=%b sel=%b", gnt, busy, sel);
        end
    end

    task automatic test_reset();
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 2'b00);
            vectors++;
            if (gnt !== 2'b00 || sel !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: gnt=%b sel=%b busy=%b want 00/0/0",
                         i, gnt, sel, busy);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] want;
        tick(1'b0, 2'b00);
        for (int i = 0; i < 18; i++) begin
            tick(1'b1, 2'b11);
            want = (i < 8) ? 2'b01 : (i < 16) ? 2'b10 : 2'b01;
            vectors++;
            if (gnt !== want || gnt !== exp_gnt() || sel !== want[1]) begin
                miscompares++;
                $display("FAIL rotation[%0d]: gnt=%b sel=%b want gnt=%b sel=%b",
                         i, gnt, sel, want, want[1]);
            end
        end
    endtask

    task automatic test_handoff();
        tick(1'b0, 2'b00);
        for (int i = 0; i < 3; i++) tick(1'b1, 2'b11);
        vectors++;
        if (gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL handoff_pre: gnt=%b want 01", gnt);
        end
        tick(1'b1, 2'b10);
        vectors++;
        if (gnt !== 2'b10 || sel !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff: gnt=%b sel=%b busy=%b want 10/1/1", gnt, sel, busy);
        end
    endtask

    task automatic test_saturate();
        tick(1'b0, 2'b00);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 2'b01);
            vectors++;
            if (gnt !== 2'b01 || sel !== 1'b0) begin
                miscompares++;
                $display("FAIL saturate[%0d]: gnt=%b sel=%b want 01/0", i, gnt, sel);
            end
        end
        // Contender arrives after saturation: hand over on the next edge
        tick(1'b1, 2'b11);
        vectors++;
        if (gnt !== 2'b10 || gnt !== exp_gnt()) begin
            miscompares++;
            $display("FAIL sat_contend: gnt=%b want 10", gnt);
        end
    endtask

    task automatic test_idle_hold();
        tick(1'b0, 2'b00);
        tick(1'b1, 2'b01);
        tick(1'b1, 2'b01);
        tick(1'b1, 2'b00);
        vectors++;
        if (gnt !== 2'b00 || busy !== 1'b0 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: gnt=%b busy=%b sel=%b want 00/0/0", gnt, busy, sel);
        end
        tick(1'b1, 2'b10);
        vectors++;
        if (gnt !== 2'b10 || sel !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_to_own1: gnt=%b sel=%b want 10/1", gnt, sel);
        end
        tick(1'b1, 2'b00);
        vectors++;
        if (gnt !== 2'b00 || sel !== 1'b1) begin
            miscompares++;
            $display("FAIL sel_hold: gnt=%b sel=%b want 00/1", gnt, sel);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 2'b00);
        tick(1'b1, 2'b10);
        tick(1'b1, 2'b10);
        tick(1'b0, 2'b10);
        vectors++;
        if (gnt !== 2'b00 || sel !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: gnt=%b sel=%b busy=%b want 00/0/0", gnt, sel, busy);
        end
        tick(1'b1, 2'b11);
        vectors++;
        if (gnt !== 2'b01 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tie: gnt=%b sel=%b want 01/0", gnt, sel);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic       rb;
        int         wait0;
        int         wait1;
        tick(1'b0, 2'b00);
        wait0 = 0;
        wait1 = 0;
        for (int i = 0; i < 600; i++) begin
            // Requests are mostly held so that rotation is exercised
            if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
            rb = ($urandom_range(0, 99) != 0);
            tick(rb, r);
            vectors++;
            if (gnt !== exp_gnt() || sel !== m_sel[0] || busy !== (m_owner >= 0)) begin
                miscompares++;
                $display("FAIL random[%0d]: req=%b gnt=%b sel=%b busy=%b want %b/%0d/%0d",
                         i, r, gnt, sel, busy, exp_gnt(), m_sel, m_owner >= 0);
            end
            // Starvation bound for continuously requesting sources
            wait0 = (rb && r[0] && !gnt[0]) ? wait0 + 1 : 0;
            wait1 = (rb && r[1] && !gnt[1]) ? wait1 + 1 : 0;
            if (wait0 > MAX_HOLD + 1 || wait1 > MAX_HOLD + 1) begin
                miscompares++;
                $display("FAIL starve[%0d]: wait0=%0d wait1=%0d limit %0d",
                         i, wait0, wait1, MAX_HOLD + 1);
                wait0 = 0;
                wait1 = 0;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 2'b00;
        m_owner     = -1;
        m_tenure    = 0;
        m_last      = 1;
        m_sel       = 0;
        test_reset();
        test_rotation();
        test_handoff();
        test_saturate();
        test_idle_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
